// File: rtl/sad_acc_if.sv
// SAD result stream in, block result stream out, for the sad_acc block.
interface sad_acc_if #(
    parameter int W     = 8,
    parameter int CNT_W = 4
);
    // Input beat stream from the SAD pipe
    logic                   sad_vld;
    logic [W+1:0]           sad_res;
    logic                   sad_rdy;
    logic [CNT_W-1:0]       blk_len;
    // Block result stream to the decision logic
    logic                   acc_vld;
    logic                   acc_rdy;
    logic [W+1+CNT_W:0]     acc_sum;
    logic [W+1:0]           acc_min;
    logic [CNT_W-1:0]       acc_idx;

    // Environment side: drives beats and result-ready
    modport master (
        output sad_vld, sad_res, blk_len, acc_rdy,
        input  sad_rdy, acc_vld, acc_sum, acc_min, acc_idx
    );

    // Accumulator side
    modport slave (
        input  sad_vld, sad_res, blk_len, acc_rdy,
        output sad_rdy, acc_vld, acc_sum, acc_min, acc_idx
    );
endinterface

// File: rtl/sad_acc.sv
// Block accumulator for SAD results: per block of blk_len beats it reports
// the sum, the minimum and the 0-based index of the first minimum.
module sad_acc #(
    parameter int W     = 8,
    parameter int CNT_W = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    sad_acc_if.slave  bus
);
    localparam int RW = W + 2;
    localparam int SW = W + 2 + CNT_W;

    typedef enum logic {ST_ACC, ST_OUT} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, len_q, len_eff, last_k;
    logic [SW-1:0]      sum_q, sum_nxt, acc_sum_q;
    logic [RW-1:0]      min_q, min_nxt, acc_min_q;
    logic [CNT_W-1:0]   idx_q, idx_nxt, acc_idx_q;
    logic               sad_rdy_int, acc_vld_int;
    logic               beat, last, take;

    // First beat always seeds the minimum; afterwards only a strictly
    // smaller value replaces it, so ties keep the earliest index.
    function automatic logic take_min(input logic first,
                                      input logic [RW-1:0] v,
                                      input logic [RW-1:0] cur);
        return first || (v < cur);
    endfunction

    // Beat qualification, last-beat detection and next accumulator values
    always_comb begin
        len_eff = (cnt_q == '0) ? bus.blk_len : len_q;
        // Length 0 wraps to all ones, i.e. last index 2^CNT_W-1
        last_k  = len_eff - CNT_W'(1);
        beat    = bus.sad_vld & sad_rdy_int;
        last    = beat && (cnt_q == last_k);
        sum_nxt = sum_q + SW'(bus.sad_res);
        take    = take_min(cnt_q == '0, bus.sad_res, min_q);
        min_nxt = take ? bus.sad_res : min_q;
        idx_nxt = take ? cnt_q : idx_q;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_ACC;
        else        state_q <= state_d;
    end

    // Next-state: collect beats until the last one, then hold the result
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACC:  if (last)        state_d = ST_OUT;
            ST_OUT:  if (bus.acc_rdy) state_d = ST_ACC;
            default:                  state_d = ST_ACC;
        endcase
    end

    // Handshake outputs decoded from registered state only
    always_comb begin
        sad_rdy_int = (state_q == ST_ACC);
        acc_vld_int = (state_q == ST_OUT);
    end

    // Accumulator, latched length and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            len_q     <= '0;
            sum_q     <= '0;
            min_q     <= '1;
            idx_q     <= '0;
            acc_sum_q <= '0;
            acc_min_q <= '1;
            acc_idx_q <= '0;
        end else if (beat) begin
            if (last) begin
                acc_sum_q <= sum_nxt;
                acc_min_q <= min_nxt;
                acc_idx_q <= idx_nxt;
                cnt_q     <= '0;
                sum_q     <= '0;
                min_q     <= '1;
                idx_q     <= '0;
            end else begin
                if (cnt_q == '0) len_q <= bus.blk_len;
                cnt_q <= cnt_q + CNT_W'(1);
                sum_q <= sum_nxt;
                min_q <= min_nxt;
                idx_q <= idx_nxt;
            end
        end
    end

    assign bus.sad_rdy = sad_rdy_int;
    assign bus.acc_vld = acc_vld_int;
    assign bus.acc_sum = acc_sum_q;
    assign bus.acc_min = acc_min_q;
    assign bus.acc_idx = acc_idx_q;
endmodule

// File: tb/tb_sad_acc.sv
// Directed bench for sad_acc with hand-computed block results.
module tb_sad_acc;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    sad_acc_if #(.W(8), .CNT_W(4)) bus ();

    sad_acc #(.W(8), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until it is accepted (bounded wait)
    task automatic send_beat(input logic [9:0] v);
        int n;
        bus.sad_vld = 1'b1;
        bus.sad_res = v;
        n = 0;
        while (bus.sad_rdy !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("sad_rdy_timeout", 32'(bus.sad_rdy), 32'd1);
        tick();
        bus.sad_vld = 1'b0;
    endtask

    task automatic check_res(input string tag, input int s, input int m, input int i);
        check({tag, "_vld"}, 32'(bus.acc_vld), 32'd1);
        check({tag, "_sum"}, 32'(bus.acc_sum), 32'(s));
        check({tag, "_min"}, 32'(bus.acc_min), 32'(m));
        check({tag, "_idx"}, 32'(bus.acc_idx), 32'(i));
        check({tag, "_rdy"}, 32'(bus.sad_rdy), 32'd0);
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        bus.sad_vld = 1'b0;
        bus.sad_res = '0;
        bus.blk_len = 4'd4;
        bus.acc_rdy = 1'b1;
        tick();
        tick();
        check("rst_vld", 32'(bus.acc_vld), 32'd0);
        check("rst_rdy", 32'(bus.sad_rdy), 32'd1);
        check("rst_sum", 32'(bus.acc_sum), 32'd0);
        check("rst_min", 32'(bus.acc_min), 32'd1023);
        check("rst_idx", 32'(bus.acc_idx), 32'd0);
        rst_n = 1'b1;
        tick();

        // Test 1: 3,7,1,5 with blk_len=4
        send_beat(10'd3); send_beat(10'd7); send_beat(10'd1);
        check("t1_early_vld", 32'(bus.acc_vld), 32'd0);
        send_beat(10'd5);
        check_res("t1", 16, 1, 2);
        tick();
        check("t1_vld_drop", 32'(bus.acc_vld), 32'd0);
        check("t1_rdy_back", 32'(bus.sad_rdy), 32'd1);

        // Test 2: 16 beats of 1023, blk_len=0
        bus.blk_len = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check("t2_early_vld", 32'(bus.acc_vld), 32'd0);
            send_beat(10'd1023);
        end
        check_res("t2", 16368, 1023, 0);
        tick();

        // Test 3: result stalled 5 cycles, a beat offered during the stall
        bus.blk_len = 4'd4;
        bus.acc_rdy = 1'b0;
        send_beat(10'd3); send_beat(10'd7); send_beat(10'd1); send_beat(10'd5);
        bus.sad_vld = 1'b1;
        bus.sad_res = 10'd100;
        for (int i = 0; i < 5; i++) begin
            check_res("t3_hold", 16, 1, 2);
            tick();
        end
        bus.acc_rdy = 1'b1;
        tick();
        bus.sad_vld = 1'b0;
        check("t3_vld_drop", 32'(bus.acc_vld), 32'd0);
        bus.blk_len = 4'd2;
        send_beat(10'd9); send_beat(10'd2);
        check_res("t3_next", 11, 2, 1);
        tick();

        // Test 4: idle gaps and blk_len change mid-block
        bus.blk_len = 4'd3;
        send_beat(10'd4);
        bus.blk_len = 4'd1;
        tick(); tick();
        check("t4_idle_vld", 32'(bus.acc_vld), 32'd0);
        send_beat(10'd4);
        check("t4_mid_vld", 32'(bus.acc_vld), 32'd0);
        send_beat(10'd2);
        check_res("t4", 10, 2, 2);
        tick();

        // Length 1: every beat is its own block
        send_beat(10'd7);
        check_res("l1", 7, 7, 0);
        tick();

        // Test 5: reset mid-block discards partial sums
        bus.blk_len = 4'd4;
        send_beat(10'd20); send_beat(10'd30);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t5_rst_vld", 32'(bus.acc_vld), 32'd0);
        check("t5_rst_min", 32'(bus.acc_min), 32'd1023);
        send_beat(10'd8); send_beat(10'd6); send_beat(10'd6);
        check("t5_early_vld", 32'(bus.acc_vld), 32'd0);
        send_beat(10'd9);
        check_res("t5", 29, 6, 1);
        tick();

        // Test 6: reset while a result is pending
        bus.acc_rdy = 1'b0;
        bus.blk_len = 4'd1;
        send_beat(10'd5);
        check_res("t6_pre", 5, 5, 0);
        rst_n = 1'b0;
        tick();
        check("t6_vld", 32'(bus.acc_vld), 32'd0);
        check("t6_rdy", 32'(bus.sad_rdy), 32'd1);
        rst_n = 1'b1;
        bus.acc_rdy = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
